weight_mem_responder: RTL and testbench

AXI4 read-channel responder backed by an on-chip weight memory; the slave end of the DDR read port that the accelerator's loader/kernel pair drives as master. Accepts one AR burst at a time and returns read-data beats with correct RLAST/RRESP, and sustains one beat per cycle under continuous RREADY. Weight contents are preloaded over a simple write port, which makes the block a drop-in replacement for external DDR in on-chip builds and in simulation.

---
 rtl/weight_mem_responder_if.sv | 31 +++
 rtl/weight_mem_responder.sv | 227 ++++++++++++++++++++++
 tb/tb_weight_mem_responder.sv | 335 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/weight_mem_responder_if.sv
// AXI4 read-address and read-data channel bundle for the weight memory responder.
// Latency: none, wires only.
// Backpressure: arready and rready carry flow control in the usual AXI sense.
interface weight_mem_responder_if #(
  parameter int DATAWIDTH = 64,
  parameter int ADDRWIDTH = 32
);
  logic [ADDRWIDTH-1:0] s_axi_araddr;
  logic                 s_axi_arvalid;
  logic                 s_axi_arready;
  logic [7:0]           s_axi_arlen;
  logic [2:0]           s_axi_arsize;
  logic [1:0]           s_axi_arburst;
  logic [DATAWIDTH-1:0] s_axi_rdata;
  logic                 s_axi_rvalid;
  logic                 s_axi_rready;
  logic                 s_axi_rlast;
  logic [1:0]           s_axi_rresp;

  modport master (
    output s_axi_araddr, s_axi_arvalid, s_axi_arlen, s_axi_arsize, s_axi_arburst,
    output s_axi_rready,
    input  s_axi_arready, s_axi_rdata, s_axi_rvalid, s_axi_rlast, s_axi_rresp
  );

  modport slave (
    input  s_axi_araddr, s_axi_arvalid, s_axi_arlen, s_axi_arsize, s_axi_arburst,
    input  s_axi_rready,
    output s_axi_arready, s_axi_rdata, s_axi_rvalid, s_axi_rlast, s_axi_rresp
  );
endinterface

// File: rtl/weight_mem_responder.sv
// AXI4 read responder backed by a preloadable on-chip weight memory, one burst at a time.
// Latency: first R beat valid two cycles after the AR handshake, then one beat per cycle.
// Backpressure: rready low holds the 2-entry output skid buffer; reads are issued only when it has room.
module weight_mem_responder #(
  parameter int                   DATAWIDTH = 64,
  parameter int                   ADDRWIDTH = 32,
  parameter int                   LG_DEPTH  = 12,
  parameter logic [ADDRWIDTH-1:0] BASE_ADDR = 32'h00070000
) (
  input  logic                     s_axis_aclk,
  input  logic                     s_axis_aresetn,
  weight_mem_responder_if.slave    axi,
  input  logic                     wr_en,
  input  logic [LG_DEPTH-1:0]      wr_addr,
  input  logic [DATAWIDTH-1:0]     wr_data
);

  localparam int                   BYTES    = DATAWIDTH / 8;
  localparam int                   LG_BYTES = $clog2(BYTES);
  localparam logic [ADDRWIDTH-1:0] BYTES_A  = ADDRWIDTH'(BYTES);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_e;

  state_e state_q, state_d;

  // Burst context latched at AR acceptance
  logic [ADDRWIDTH-1:0] addr_q, addr_d;
  logic [7:0]           len_q, len_d;
  logic [1:0]           burst_q, burst_d;
  logic                 slverr_q, slverr_d;
  logic [7:0]           beat_q, beat_d;

  // Beat whose memory read is in flight this cycle
  logic                 infl_q, infl_d;
  logic [1:0]           infl_resp_q, infl_resp_d;
  logic                 infl_last_q, infl_last_d;
  logic                 infl_zero_q, infl_zero_d;

  // Two-entry skid buffer
  logic [1:0]           cnt_q, cnt_d;
  logic                 wr_ptr_q, wr_ptr_d;
  logic                 rd_ptr_q, rd_ptr_d;
  logic [DATAWIDTH-1:0] fifo_dat_q [2];
  logic [DATAWIDTH-1:0] fifo_dat_d [2];
  logic [1:0]           fifo_resp_q [2];
  logic [1:0]           fifo_resp_d [2];
  logic                 fifo_last_q [2];
  logic                 fifo_last_d [2];

  logic [DATAWIDTH-1:0] mem [2**LG_DEPTH];
  logic [DATAWIDTH-1:0] rd_data_q;

  logic                 arready, ar_hs, ar_slverr;
  logic                 issue, last_issue, rd_en, pop;
  logic [1:0]           occ_after;
  logic [ADDRWIDTH-1:0] off, word, wrap_mask, incr_addr, next_addr;
  logic                 decerr;
  logic [LG_DEPTH-1:0]  rd_word;
  logic [DATAWIDTH-1:0] in_dat;
  logic                 r_vld, r_last;
  logic [DATAWIDTH-1:0] r_dat;
  logic [1:0]           r_resp;

  // AR acceptance and burst-wide error classification
  always_comb begin
    ar_hs     = axi.s_axi_arvalid && arready;
    ar_slverr = (axi.s_axi_arsize != 3'(LG_BYTES)) ||
                (axi.s_axi_arburst == 2'b11) ||
                ((axi.s_axi_arburst == 2'b10) &&
                 !(axi.s_axi_arlen inside {8'd1, 8'd3, 8'd7, 8'd15}));
  end

  // Per-beat address decode and next-address generation
  always_comb begin
    off       = addr_q - BASE_ADDR;
    word      = off >> LG_BYTES;
    decerr    = (addr_q < BASE_ADDR) || ((word >> LG_DEPTH) != '0);
    rd_word   = word[LG_DEPTH-1:0];
    incr_addr = addr_q + BYTES_A;
    wrap_mask = ADDRWIDTH'({len_q, {LG_BYTES{1'b1}}});
    case (burst_q)
      2'b00:   next_addr = addr_q;
      2'b10:   next_addr = (addr_q & ~wrap_mask) | (incr_addr & wrap_mask);
      default: next_addr = incr_addr;
    endcase
  end

  // Skid buffer head: stored entry first, otherwise the beat arriving from memory
  always_comb begin
    in_dat = infl_zero_q ? '0 : rd_data_q;
    r_vld  = (cnt_q != 2'd0) || infl_q;
    r_dat  = '0;
    r_resp = 2'b00;
    r_last = 1'b0;
    if (cnt_q != 2'd0) begin
      r_dat  = fifo_dat_q[rd_ptr_q];
      r_resp = fifo_resp_q[rd_ptr_q];
      r_last = fifo_last_q[rd_ptr_q];
    end else if (infl_q) begin
      r_dat  = in_dat;
      r_resp = infl_resp_q;
      r_last = infl_last_q;
    end
    pop       = r_vld && axi.s_axi_rready;
    occ_after = cnt_q + {1'b0, infl_q} - {1'b0, pop};
  end

  // FSM outputs: AR ready only while idle and out of reset, issue while buffer has room
  always_comb begin
    arready    = (state_q == IDLE) && s_axis_aresetn;
    issue      = (state_q == ISSUE) && (occ_after < 2'd2);
    last_issue = (beat_q == len_q);
    rd_en      = issue && !decerr;
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (ar_hs) state_d = ISSUE;
      ISSUE:   if (issue && last_issue) state_d = DRAIN;
      DRAIN:   if (occ_after == 2'd0) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
    if (!s_axis_aresetn) state_q <= IDLE;
    else                 state_q <= state_d;
  end

  // Datapath next values: burst context, in-flight beat, skid buffer
  always_comb begin
    addr_d      = addr_q;
    len_d       = len_q;
    burst_d     = burst_q;
    slverr_d    = slverr_q;
    beat_d      = beat_q;
    infl_d      = issue;
    infl_resp_d = infl_resp_q;
    infl_last_d = infl_last_q;
    infl_zero_d = infl_zero_q;
    cnt_d       = occ_after;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    fifo_dat_d  = fifo_dat_q;
    fifo_resp_d = fifo_resp_q;
    fifo_last_d = fifo_last_q;

    if (ar_hs) begin
      addr_d   = axi.s_axi_araddr;
      len_d    = axi.s_axi_arlen;
      burst_d  = axi.s_axi_arburst;
      slverr_d = ar_slverr;
      beat_d   = 8'd0;
    end

    if (issue) begin
      addr_d      = next_addr;
      beat_d      = beat_q + 8'd1;
      infl_resp_d = decerr ? 2'b11 : (slverr_q ? 2'b10 : 2'b00);
      infl_zero_d = decerr || slverr_q;
      infl_last_d = last_issue;
    end

    if (pop && (cnt_q != 2'd0)) rd_ptr_d = ~rd_ptr_q;

    // The arriving beat is stored unless it bypassed straight out this cycle
    if (infl_q && !((cnt_q == 2'd0) && pop)) begin
      fifo_dat_d[wr_ptr_q]  = in_dat;
      fifo_resp_d[wr_ptr_q] = infl_resp_q;
      fifo_last_d[wr_ptr_q] = infl_last_q;
      wr_ptr_d              = ~wr_ptr_q;
    end
  end

  // Datapath registers; reset abandons any burst in progress
  always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
    if (!s_axis_aresetn) begin
      addr_q      <= '0;
      len_q       <= '0;
      burst_q     <= '0;
      slverr_q    <= 1'b0;
      beat_q      <= '0;
      infl_q      <= 1'b0;
      infl_resp_q <= '0;
      infl_last_q <= 1'b0;
      infl_zero_q <= 1'b0;
      cnt_q       <= '0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      fifo_dat_q  <= '{default: '0};
      fifo_resp_q <= '{default: '0};
      fifo_last_q <= '{default: 1'b0};
    end else begin
      addr_q      <= addr_d;
      len_q       <= len_d;
      burst_q     <= burst_d;
      slverr_q    <= slverr_d;
      beat_q      <= beat_d;
      infl_q      <= infl_d;
      infl_resp_q <= infl_resp_d;
      infl_last_q <= infl_last_d;
      infl_zero_q <= infl_zero_d;
      cnt_q       <= cnt_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      fifo_dat_q  <= fifo_dat_d;
      fifo_resp_q <= fifo_resp_d;
      fifo_last_q <= fifo_last_d;
    end
  end

  // Weight memory: preload write and read-first synchronous read, contents kept across reset
  always_ff @(posedge s_axis_aclk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data_q <= mem[rd_word];
  end

  assign axi.s_axi_arready = arready;
  assign axi.s_axi_rvalid  = r_vld;
  assign axi.s_axi_rdata   = r_dat;
  assign axi.s_axi_rresp   = r_resp;
  assign axi.s_axi_rlast   = r_last;

endmodule

// File: tb/tb_weight_mem_responder.sv
// Directed bench for weight_mem_responder: INCR/WRAP/FIXED bursts, errors, reset, preload collision.
// Latency: checks first beat two cycles after AR and back-to-back beats under rready high.
// Backpressure: drives rready patterns and checks stall stability and beat count.
module tb_weight_mem_responder;
  localparam int DW  = 64;
  localparam int AW  = 32;
  localparam int LGD = 12;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic wr_en = 1'b0;
  logic [LGD-1:0] wr_addr = '0;
  logic [DW-1:0]  wr_data = '0;

  always #5 clk = ~clk;

  weight_mem_responder_if #(.DATAWIDTH(DW), .ADDRWIDTH(AW)) axi ();

  weight_mem_responder #(
    .DATAWIDTH(DW), .ADDRWIDTH(AW), .LG_DEPTH(LGD), .BASE_ADDR(32'h00070000)
  ) dut (
    .s_axis_aclk   (clk),
    .s_axis_aresetn(rst_n),
    .axi           (axi),
    .wr_en         (wr_en),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [DW-1:0] got_dat [$];
  logic [1:0]    got_resp[$];
  logic          got_last[$];
  int            got_cyc [$];
  int            stall_bad;
  int            stall_seen;
  int            c0;
  logic          ar_seen;

  task automatic preload(input int idx, input logic [DW-1:0] d);
    wr_en   = 1'b1;
    wr_addr = idx[LGD-1:0];
    wr_data = d;
    @(posedge clk); #1;
    wr_en   = 1'b0;
  endtask

  // Present one AR for a single cycle; record whether it was accepted and in which cycle.
  task automatic send_ar(input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    axi.s_axi_araddr  = addr;
    axi.s_axi_arlen   = len;
    axi.s_axi_arsize  = size;
    axi.s_axi_arburst = burst;
    axi.s_axi_arvalid = 1'b1;
    @(negedge clk);
    ar_seen = axi.s_axi_arready;
    c0      = cyc;
    @(posedge clk); #1;
    axi.s_axi_arvalid = 1'b0;
  endtask

  // Gather up to n handshaken beats with rready from pat (bit k = k-th cycle), bounded to 100 cycles.
  task automatic collect(input int n, input logic [31:0] pat);
    logic [DW-1:0] pd;
    logic [1:0]    pr;
    logic          pl;
    logic          have;
    got_dat.delete(); got_resp.delete(); got_last.delete(); got_cyc.delete();
    stall_bad = 0; stall_seen = 0; have = 1'b0;
    pd = '0; pr = '0; pl = 1'b0;
    for (int k = 0; k < 100 && got_dat.size() < n; k++) begin
      axi.s_axi_rready = pat[k[4:0]];
      @(negedge clk);
      if (have) begin
        stall_seen++;
        if (!axi.s_axi_rvalid || axi.s_axi_rdata !== pd || axi.s_axi_rresp !== pr ||
            axi.s_axi_rlast !== pl)
          stall_bad++;
      end
      have = 1'b0;
      if (axi.s_axi_rvalid && axi.s_axi_rready) begin
        got_dat.push_back(axi.s_axi_rdata);
        got_resp.push_back(axi.s_axi_rresp);
        got_last.push_back(axi.s_axi_rlast);
        got_cyc.push_back(cyc);
      end else if (axi.s_axi_rvalid) begin
        have = 1'b1;
        pd = axi.s_axi_rdata; pr = axi.s_axi_rresp; pl = axi.s_axi_rlast;
      end
      @(posedge clk); #1;
    end
    axi.s_axi_rready = 1'b0;
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (axi.s_axi_arready !== 1'b0) begin n_fail++; $display("FAIL rst_arready: got %b expected 0", axi.s_axi_arready); end
    n_checks++;
    if (axi.s_axi_rvalid !== 1'b0 || axi.s_axi_rlast !== 1'b0) begin
      n_fail++; $display("FAIL rst_rvalid_rlast: got %b%b expected 00", axi.s_axi_rvalid, axi.s_axi_rlast);
    end
    n_checks++;
    if (axi.s_axi_rresp !== 2'b00 || axi.s_axi_rdata !== '0) begin
      n_fail++; $display("FAIL rst_rresp_rdata: got %b %h expected 00 0", axi.s_axi_rresp, axi.s_axi_rdata);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (axi.s_axi_arready !== 1'b1) begin n_fail++; $display("FAIL rst_release_arready: got %b expected 1", axi.s_axi_arready); end
    @(posedge clk); #1;
  endtask

  task automatic test_incr;
    send_ar(32'h00070000, 8'd7, 3'd3, 2'b01);
    n_checks++;
    if (ar_seen !== 1'b1) begin n_fail++; $display("FAIL incr_ar: got %b expected 1", ar_seen); end
    collect(8, 32'hFFFF_FFFF);
    n_checks++;
    if (got_dat.size() != 8) begin n_fail++; $display("FAIL incr_count: got %0d expected 8", got_dat.size()); end
    for (int i = 0; i < got_dat.size(); i++) begin
      n_checks++;
      if (got_dat[i] !== 64'(i) || got_resp[i] !== 2'b00 || got_last[i] !== (i == 7) ||
          got_cyc[i] != c0 + 2 + i) begin
        n_fail++;
        $display("FAIL incr_beat[%0d]: got d=%h r=%b l=%b cyc=%0d expected d=%h r=00 l=%b cyc=%0d",
                 i, got_dat[i], got_resp[i], got_last[i], got_cyc[i] - c0, 64'(i), (i == 7), 2 + i);
      end
    end
  endtask

  task automatic test_back_to_back;
    int last_cyc;
    send_ar(32'h00070020, 8'd1, 3'd3, 2'b01);
    collect(2, 32'hFFFF_FFFF);
    n_checks++;
    if (got_dat.size() != 2 || got_dat[0] !== 64'd4 || got_dat[1] !== 64'd5 || got_last[1] !== 1'b1) begin
      n_fail++; $display("FAIL b2b_first: got %0d beats expected words 4,5 with rlast on second", got_dat.size());
    end
    last_cyc = (got_cyc.size() > 0) ? got_cyc[got_cyc.size()-1] : -100;
    // Next AR presented in the cycle right after the rlast handshake
    send_ar(32'h00070030, 8'd0, 3'd3, 2'b01);
    n_checks++;
    if (ar_seen !== 1'b1 || c0 != last_cyc + 1) begin
      n_fail++; $display("FAIL b2b_turnaround: got arready=%b at +%0d expected 1 at +1", ar_seen, c0 - last_cyc);
    end
    collect(1, 32'hFFFF_FFFF);
    n_checks++;
    if (got_dat.size() != 1 || got_dat[0] !== 64'd6 || got_last[0] !== 1'b1 || got_cyc[0] != c0 + 2) begin
      n_fail++; $display("FAIL b2b_len0: got %0d beats expected one beat data 6 rlast 1 in cycle 2", got_dat.size());
    end
  endtask

  task automatic test_wrap;
    int exp_w [4];
    exp_w = '{2, 3, 0, 1};
    send_ar(32'h00070010, 8'd3, 3'd3, 2'b10);
    collect(4, 32'hFFFF_FFFF);
    n_checks++;
    if (got_dat.size() != 4) begin n_fail++; $display("FAIL wrap_count: got %0d expected 4", got_dat.size()); end
    for (int i = 0; i < got_dat.size(); i++) begin
      n_checks++;
      if (got_dat[i] !== 64'(exp_w[i]) || got_resp[i] !== 2'b00 || got_last[i] !== (i == 3)) begin
        n_fail++;
        $display("FAIL wrap_beat[%0d]: got d=%h r=%b l=%b expected d=%h r=00 l=%b",
                 i, got_dat[i], got_resp[i], got_last[i], 64'(exp_w[i]), (i == 3));
      end
    end
  endtask

  task automatic test_fixed_backpressure;
    logic [31:0] pat;
    int extra;
    for (int i = 0; i < 32; i++) pat[i] = (i == 0) || (i % 3 == 1);
    send_ar(32'h00070008, 8'd3, 3'd3, 2'b00);
    collect(4, pat);
    n_checks++;
    if (got_dat.size() != 4) begin n_fail++; $display("FAIL fixed_count: got %0d expected 4", got_dat.size()); end
    for (int i = 0; i < got_dat.size(); i++) begin
      n_checks++;
      if (got_dat[i] !== 64'd1 || got_resp[i] !== 2'b00 || got_last[i] !== (i == 3)) begin
        n_fail++;
        $display("FAIL fixed_beat[%0d]: got d=%h r=%b l=%b expected d=1 r=00 l=%b",
                 i, got_dat[i], got_resp[i], got_last[i], (i == 3));
      end
    end
    n_checks++;
    if (stall_bad != 0 || stall_seen != 6) begin
      n_fail++; $display("FAIL fixed_stall: got %0d unstable of %0d stalls expected 0 of 6", stall_bad, stall_seen);
    end
    extra = 0;
    axi.s_axi_rready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (axi.s_axi_rvalid) extra++;
      @(posedge clk); #1;
    end
    axi.s_axi_rready = 1'b0;
    n_checks++;
    if (extra != 0) begin n_fail++; $display("FAIL fixed_extra: got %0d extra beats expected 0", extra); end
  endtask

  task automatic test_errors;
    // Below the base address: every beat decode-errors
    send_ar(32'h0006FFF8, 8'd1, 3'd3, 2'b00);
    collect(2, 32'hFFFF_FFFF);
    n_checks++;
    if (got_dat.size() != 2) begin n_fail++; $display("FAIL err_low_count: got %0d expected 2", got_dat.size()); end
    for (int i = 0; i < got_dat.size(); i++) begin
      n_checks++;
      if (got_dat[i] !== '0 || got_resp[i] !== 2'b11 || got_last[i] !== (i == 1)) begin
        n_fail++; $display("FAIL err_low[%0d]: got d=%h r=%b l=%b expected d=0 r=11", i, got_dat[i], got_resp[i], got_last[i]);
      end
    end
    // Wrong beat size: whole burst slave-errors with zero data
    send_ar(32'h00070000, 8'd1, 3'd2, 2'b01);
    collect(2, 32'hFFFF_FFFF);
    n_checks++;
    if (got_dat.size() != 2) begin n_fail++; $display("FAIL err_size_count: got %0d expected 2", got_dat.size()); end
    for (int i = 0; i < got_dat.size(); i++) begin
      n_checks++;
      if (got_dat[i] !== '0 || got_resp[i] !== 2'b10 || got_last[i] !== (i == 1)) begin
        n_fail++; $display("FAIL err_size[%0d]: got d=%h r=%b l=%b expected d=0 r=10", i, got_dat[i], got_resp[i], got_last[i]);
      end
    end
    // Last word then one past the end
    send_ar(32'h00077FF8, 8'd1, 3'd3, 2'b01);
    collect(2, 32'hFFFF_FFFF);
    n_checks++;
    if (got_dat.size() != 2 || got_dat[0] !== 64'hDEAD_BEEF_0123_4567 || got_resp[0] !== 2'b00 || got_last[0] !== 1'b0) begin
      n_fail++; $display("FAIL err_top_beat0: got %0d beats expected first d=deadbeef01234567 r=00", got_dat.size());
    end
    n_checks++;
    if (got_dat.size() != 2 || got_dat[1] !== '0 || got_resp[1] !== 2'b11 || got_last[1] !== 1'b1) begin
      n_fail++; $display("FAIL err_top_beat1: got %0d beats expected second d=0 r=11 l=1", got_dat.size());
    end
    // Reserved burst type
    send_ar(32'h00070008, 8'd0, 3'd3, 2'b11);
    collect(1, 32'hFFFF_FFFF);
    n_checks++;
    if (got_dat.size() != 1 || got_dat[0] !== '0 || got_resp[0] !== 2'b10 || got_last[0] !== 1'b1) begin
      n_fail++; $display("FAIL err_burst11: got %0d beats expected one d=0 r=10 l=1", got_dat.size());
    end
    // WRAP with an illegal length
    send_ar(32'h00070000, 8'd2, 3'd3, 2'b10);
    collect(3, 32'hFFFF_FFFF);
    n_checks++;
    if (got_dat.size() != 3 || got_resp[0] !== 2'b10 || got_resp[2] !== 2'b10 || got_dat[0] !== '0 || got_last[2] !== 1'b1) begin
      n_fail++; $display("FAIL err_wraplen: got %0d beats expected three d=0 r=10", got_dat.size());
    end
  endtask

  task automatic test_reset_midburst;
    send_ar(32'h00070000, 8'd15, 3'd3, 2'b01);
    collect(3, 32'hFFFF_FFFF);
    n_checks++;
    if (got_dat.size() != 3 || got_dat[2] !== 64'd2) begin
      n_fail++; $display("FAIL mid_pre: got %0d beats expected 3 ending in data 2", got_dat.size());
    end
    rst_n = 1'b0;
    #2;
    n_checks++;
    if (axi.s_axi_rvalid !== 1'b0 || axi.s_axi_rdata !== '0) begin
      n_fail++; $display("FAIL mid_rvalid: got %b %h expected 0 0", axi.s_axi_rvalid, axi.s_axi_rdata);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (axi.s_axi_arready !== 1'b1 || axi.s_axi_rvalid !== 1'b0) begin
      n_fail++; $display("FAIL mid_release: got arready=%b rvalid=%b expected 1 0", axi.s_axi_arready, axi.s_axi_rvalid);
    end
    @(posedge clk); #1;
    send_ar(32'h00070018, 8'd0, 3'd3, 2'b01);
    collect(1, 32'hFFFF_FFFF);
    n_checks++;
    if (got_dat.size() != 1 || got_dat[0] !== 64'd3 || got_last[0] !== 1'b1 || got_cyc[0] != c0 + 2) begin
      n_fail++; $display("FAIL mid_after: got %0d beats expected one d=3 l=1 in cycle 2", got_dat.size());
    end
  endtask

  task automatic test_preload_collision;
    send_ar(32'h00070000, 8'd7, 3'd3, 2'b01);
    fork
      collect(8, 32'hFFFF_FFFF);
      begin
        // Word 5 is read five cycles after the first issue cycle
        repeat (5) @(posedge clk);
        #1;
        wr_en = 1'b1; wr_addr = 12'd5; wr_data = 64'hAA;
        @(posedge clk); #1;
        wr_en = 1'b0;
      end
    join
    n_checks++;
    if (got_dat.size() != 8 || got_dat[5] !== 64'd5 || got_dat[6] !== 64'd6) begin
      n_fail++; $display("FAIL coll_old: got %0d beats expected word 5 = 5 (old)", got_dat.size());
    end
    send_ar(32'h00070028, 8'd0, 3'd3, 2'b01);
    collect(1, 32'hFFFF_FFFF);
    n_checks++;
    if (got_dat.size() != 1 || got_dat[0] !== 64'hAA) begin
      n_fail++; $display("FAIL coll_new: got %0d beats expected data aa", got_dat.size());
    end
  endtask

  initial begin
    axi.s_axi_araddr  = '0;
    axi.s_axi_arvalid = 1'b0;
    axi.s_axi_arlen   = '0;
    axi.s_axi_arsize  = '0;
    axi.s_axi_arburst = '0;
    axi.s_axi_rready  = 1'b0;
    test_reset();
    for (int i = 0; i < 16; i++) preload(i, 64'(i));
    preload(4095, 64'hDEAD_BEEF_0123_4567);
    test_incr();
    test_back_to_back();
    test_wrap();
    test_fixed_backpressure();
    test_errors();
    test_reset_midburst();
    test_preload_collision();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
